// File: rtl/logic_thief_pkg.sv
// Shared constants and state encoding for the logic_thief_trig capture block.
package logic_thief_pkg;

    localparam logic [31:0] CMD_CLEAR = 32'hDEADDEAD;
    localparam logic [31:0] CMD_ARM   = 32'hDEADCAFE;
    localparam logic [31:0] CMD_FORCE = 32'hDEADF00D;

    localparam int unsigned STATUS_WIDTH = 8;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFill  = 3'd1,
        StArmed = 3'd2,
        StPost  = 3'd3,
        StDone  = 3'd4
    } state_e;

endpackage

// File: rtl/logic_thief_trig_if.sv
// Software/hardware register interface of the capture block: command, trigger setup, readback.
interface logic_thief_trig_if #(
    parameter int unsigned LOG2_DEEP  = 8,
    parameter int unsigned TRIG_WIDTH = 8,
    parameter int unsigned OUT_WIDTH  = 192
);
    logic [31:0]           cmd_i;
    logic [LOG2_DEEP-1:0]  pretrig_i;
    logic [TRIG_WIDTH-1:0] trig_mask_i;
    logic [TRIG_WIDTH-1:0] trig_value_i;
    logic [31:0]           addr_i;
    logic [OUT_WIDTH-1:0]  data_o;
    logic [2:0]            state_o;
    logic                  done_o;
    logic [LOG2_DEEP-1:0]  trig_addr_o;

    modport master (
        output cmd_i, pretrig_i, trig_mask_i, trig_value_i, addr_i,
        input  data_o, state_o, done_o, trig_addr_o
    );

    modport slave (
        input  cmd_i, pretrig_i, trig_mask_i, trig_value_i, addr_i,
        output data_o, state_o, done_o, trig_addr_o
    );

endinterface

// File: rtl/lt_capture_ram.sv
// Simple dual-port capture RAM: port A write-only, port B registered read, read-first.
module lt_capture_ram #(
    parameter int unsigned Width     = 8,
    parameter int unsigned AddrWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [Width-1:0]     wdata_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [Width-1:0]     rdata_o
);

    logic [Width-1:0] mem_q [0:(2**AddrWidth)-1];

    // Non-blocking read and write in one block give old data on a same-address collision.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/logic_thief_trig.sv
// Logic analyser: circular capture of a probe vector with pre-trigger window and masked trigger.
module logic_thief_trig
    import logic_thief_pkg::*;
#(
    parameter int unsigned PROBE_WIDTH = 171,
    parameter int unsigned LOG2_DEEP   = 8,
    parameter int unsigned TRIG_LSB    = 64,
    parameter int unsigned TRIG_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH   = 192
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [PROBE_WIDTH-1:0] probe_i,
    logic_thief_trig_if.slave      bus_io
);

    localparam logic [LOG2_DEEP:0] DepthCnt = {1'b1, {LOG2_DEEP{1'b0}}};
    localparam logic [LOG2_DEEP:0] PostOne  = {{LOG2_DEEP{1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [LOG2_DEEP-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LOG2_DEEP-1:0]   pre_cnt_q, pre_cnt_d;
    logic [LOG2_DEEP-1:0]   pre_len_q, pre_len_d;
    logic [LOG2_DEEP:0]     post_cnt_q, post_cnt_d;
    logic [LOG2_DEEP-1:0]   trig_addr_q, trig_addr_d;
    logic [OUT_WIDTH-1:0]   data_q, data_d;

    logic                   we;
    logic                   hit;
    logic                   cmd_clear, cmd_arm, cmd_force;
    logic [LOG2_DEEP:0]     post_len;
    logic [LOG2_DEEP-1:0]   rd_addr;
    logic [PROBE_WIDTH-1:0] rd_data;
    logic [STATUS_WIDTH-1:0] status;
    logic                   unused_addr;

    assign cmd_clear = (bus_io.cmd_i == CMD_CLEAR);
    assign cmd_arm   = (bus_io.cmd_i == CMD_ARM);
    assign cmd_force = (bus_io.cmd_i == CMD_FORCE);

    assign hit = (((probe_i[TRIG_LSB +: TRIG_WIDTH] ^ bus_io.trig_value_i)
                   & bus_io.trig_mask_i) == '0);

    // Post-samples include the trigger sample itself.
    assign post_len = DepthCnt - {1'b0, pre_len_q};

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        pre_cnt_d   = pre_cnt_q;
        pre_len_d   = pre_len_q;
        post_cnt_d  = post_cnt_q;
        trig_addr_d = trig_addr_q;
        we          = 1'b0;

        if (cmd_clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_arm) begin
                        pre_len_d = bus_io.pretrig_i;
                        wr_ptr_d  = '0;
                        pre_cnt_d = '0;
                        state_d   = (bus_io.pretrig_i == '0) ? StArmed : StFill;
                    end
                end
                StFill: begin
                    we        = 1'b1;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    pre_cnt_d = pre_cnt_q + 1'b1;
                    if (pre_cnt_q == pre_len_q - 1'b1) begin
                        state_d = StArmed;
                    end
                end
                StArmed: begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (hit || cmd_force) begin
                        trig_addr_d = wr_ptr_q;
                        post_cnt_d  = PostOne;
                        state_d     = (post_len == PostOne) ? StDone : StPost;
                    end
                end
                StPost: begin
                    we         = 1'b1;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    post_cnt_d = post_cnt_q + 1'b1;
                    if (post_cnt_d == post_len) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Logical address 0 is the oldest retained sample.
    assign rd_addr = trig_addr_q - pre_len_q + bus_io.addr_i[LOG2_DEEP-1:0];
    assign unused_addr = ^bus_io.addr_i[31:LOG2_DEEP];

    lt_capture_ram #(
        .Width     (PROBE_WIDTH),
        .AddrWidth (LOG2_DEEP)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (probe_i),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign status = {state_q == StDone, state_q, 4'b0000};

    always_comb begin
        data_d                              = '0;
        data_d[PROBE_WIDTH-1:0]             = rd_data;
        data_d[OUT_WIDTH-1 -: STATUS_WIDTH] = status;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            pre_cnt_q   <= '0;
            pre_len_q   <= '0;
            post_cnt_q  <= '0;
            trig_addr_q <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            pre_cnt_q   <= pre_cnt_d;
            pre_len_q   <= pre_len_d;
            post_cnt_q  <= post_cnt_d;
            trig_addr_q <= trig_addr_d;
            data_q      <= data_d;
        end
    end

    assign bus_io.data_o      = data_q;
    assign bus_io.state_o     = state_q;
    assign bus_io.done_o      = (state_q == StDone);
    assign bus_io.trig_addr_o = trig_addr_q;

endmodule

// File: tb/tb_logic_thief_trig.sv
// Randomised bench for logic_thief_trig against a sample-history reference model.
module tb_logic_thief_trig;

    localparam int PW    = 171;
    localparam int LD    = 8;
    localparam int TL    = 64;
    localparam int TW    = 8;
    localparam int OW    = 192;
    localparam int DEPTH = 256;

    localparam logic [31:0] C_CLEAR = 32'hDEADDEAD;
    localparam logic [31:0] C_ARM   = 32'hDEADCAFE;
    localparam logic [31:0] C_FORCE = 32'hDEADF00D;
    localparam logic [31:0] C_NOP   = 32'h0;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [PW-1:0] probe_i;

    logic_thief_trig_if #(.LOG2_DEEP(LD), .TRIG_WIDTH(TW), .OUT_WIDTH(OW)) bus ();

    logic_thief_trig #(
        .PROBE_WIDTH (PW),
        .LOG2_DEEP   (LD),
        .TRIG_LSB    (TL),
        .TRIG_WIDTH  (TW),
        .OUT_WIDTH   (OW)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .probe_i (probe_i),
        .bus_io  (bus)
    );

    always #5 clk_i = ~clk_i;

    int            n_vec = 0;
    int            n_err = 0;
    logic [PW-1:0] hist [0:4095];

    task automatic check_eq(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [PW-1:0] rand_probe();
        logic [191:0] t;
        for (int i = 0; i < 6; i++) t[i*32 +: 32] = $urandom();
        return t[PW-1:0];
    endfunction

    function automatic bit is_hit(input logic [7:0] f, input logic [7:0] m, input logic [7:0] v);
        return ((f ^ v) & m) == 8'h00;
    endfunction

    // Field that avoids a hit where the mask allows it.
    function automatic logic [7:0] miss_field(input logic [7:0] m, input logic [7:0] v);
        logic [7:0] f;
        f = 8'($urandom());
        for (int i = 0; i < 16 && is_hit(f, m, v); i++) f = 8'($urandom());
        return f;
    endfunction

    task automatic do_clear();
        bus.cmd_i = C_CLEAR;
        tick();
        check_eq("clear_state", bus.state_o, 0);
        check_eq("clear_done", bus.done_o, 0);
    endtask

    task automatic arm(input int pre, input logic [7:0] m, input logic [7:0] v);
        bus.pretrig_i    = LD'(pre);
        bus.trig_mask_i  = m;
        bus.trig_value_i = v;
        bus.cmd_i        = C_ARM;
        probe_i          = rand_probe();
        tick();
    endtask

    // Drive `count` ARM cycles; field hits only at cycle hit_at.
    task automatic drive_cycles(input int count, input logic [7:0] m, input logic [7:0] v,
                                input int hit_at);
        logic [PW-1:0] p;
        for (int n = 0; n < count; n++) begin
            p = rand_probe();
            p[TL +: TW] = (n == hit_at) ? (v ^ (8'($urandom()) & ~m)) : miss_field(m, v);
            probe_i   = p;
            bus.cmd_i = C_ARM;
            tick();
        end
    endtask

    task automatic run_capture(input string tag, input int pre, input logic [7:0] m,
                               input logic [7:0] v, input int hit_a, input int hit_b,
                               input int force_n, input int hit_pct);
        int            t;
        int            done_n;
        int            exp_done;
        int            k;
        int            addrs [5];
        logic [7:0]    f;
        logic [PW-1:0] p;
        logic [OW-1:0] exp;
        t      = -1;
        done_n = -1;
        arm(pre, m, v);
        for (int n = 0; n < 4000; n++) begin
            if (n == hit_a || n == hit_b || ($urandom_range(99) < 32'(hit_pct)))
                f = v ^ (8'($urandom()) & ~m);
            else
                f = miss_field(m, v);
            p = rand_probe();
            p[TL +: TW] = f;
            hist[n]     = p;
            probe_i     = p;
            bus.cmd_i   = (n == force_n) ? C_FORCE : C_ARM;
            if (t < 0 && n >= pre && (is_hit(f, m, v) || n == force_n)) t = n;
            tick();
            if (bus.done_o) begin
                done_n = n;
                break;
            end
        end
        bus.cmd_i = C_ARM;
        exp_done  = (t < 0) ? -1 : t + DEPTH - pre - 1;
        check_eq({tag, "_done_cycle"}, done_n, exp_done);
        if (done_n < 0 || t < 0) return;
        check_eq({tag, "_trig_addr"}, bus.trig_addr_o, t % DEPTH);
        check_eq({tag, "_state_done"}, bus.state_o, 4);
        addrs = '{0, pre, DEPTH - 1, $urandom_range(DEPTH - 1), $urandom_range(DEPTH - 1)};
        foreach (addrs[i]) begin
            k = addrs[i];
            bus.addr_i = 32'(k) | ($urandom() & 32'hFFFF_FF00);
            tick();
            tick();
            exp               = '0;
            exp[PW-1:0]       = hist[t - pre + k];
            exp[OW-1 -: 8]    = 8'hC0;
            check_eq($sformatf("%s_rd%0d", tag, k), bus.data_o, exp);
        end
        for (int i = 0; i < 4; i++) tick();
        check_eq({tag, "_arm_held"}, bus.state_o, 4);
        check_eq({tag, "_done_held"}, bus.done_o, 1);
    endtask

    initial begin
        probe_i          = '0;
        bus.cmd_i        = C_NOP;
        bus.pretrig_i    = '0;
        bus.trig_mask_i  = '0;
        bus.trig_value_i = '0;
        bus.addr_i       = '0;
        #12;
        check_eq("rst_state", bus.state_o, 0);
        check_eq("rst_done", bus.done_o, 0);
        check_eq("rst_trig_addr", bus.trig_addr_o, 0);
        check_eq("rst_data", bus.data_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();

        do_clear();
        run_capture("pre16", 16, 8'hFF, 8'h80, 16, -1, -1, 0);
        do_clear();
        run_capture("fill_hit", 32, 8'hFF, 8'h3C, 5, 40, 10, 0);

        // CLEAR while in POST.
        do_clear();
        arm(16, 8'hFF, 8'h80);
        drive_cycles(100, 8'hFF, 8'h80, 20);
        check_eq("mid_post_state", bus.state_o, 3);
        bus.cmd_i = C_CLEAR;
        tick();
        check_eq("mid_clear_state", bus.state_o, 0);
        check_eq("mid_clear_done", bus.done_o, 0);
        tick();
        tick();
        check_eq("mid_clear_done_held", bus.done_o, 0);
        bus.cmd_i = C_NOP;
        tick();

        // Asynchronous reset while ARMED.
        arm(8, 8'hFF, 8'h55);
        drive_cycles(50, 8'hFF, 8'h55, -1);
        check_eq("armed_state", bus.state_o, 2);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("arst_state", bus.state_o, 0);
        check_eq("arst_done", bus.done_o, 0);
        check_eq("arst_trig_addr", bus.trig_addr_o, 0);
        check_eq("arst_data", bus.data_o, 0);
        tick();
        rst_ni    = 1'b1;
        bus.cmd_i = C_NOP;
        for (int i = 0; i < 4; i++) tick();
        check_eq("post_rst_state", bus.state_o, 0);
        check_eq("post_rst_status", bus.data_o[OW-1:PW], 0);

        do_clear();
        run_capture("pre0", 0, 8'h00, 8'h00, -1, -1, -1, 0);
        do_clear();
        run_capture("force", 255, 8'hFF, 8'hA5, -1, -1, 1000, 0);

        for (int r = 0; r < 3; r++) begin
            int pre;
            pre = $urandom_range(1, 255);
            do_clear();
            run_capture($sformatf("rnd%0d", r), pre, 8'($urandom()), 8'($urandom()),
                        -1, -1, pre + 400, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/logic_thief_trig.md
Name: logic_thief_trig

Overview:
Parametrised successor to the 256-entry capture logic analyser. It records a PROBE_WIDTH-bit probe vector into a circular capture RAM with a programmable pre-trigger window and a masked-compare trigger. It sits beside the datapath under test and is read back through the software/hardware register interface (cmd_i / addr_i / data_o). Readback addresses are logical: address 0 is the oldest retained sample, independent of where the RAM pointer wrapped.

Parameters:
PROBE_WIDTH, 171, width of captured probe vector
LOG2_DEEP, 8, log2 of capture depth; DEPTH = 2**LOG2_DEEP
TRIG_LSB, 64, lowest probe bit of trigger field
TRIG_WIDTH, 8, width of trigger field; TRIG_LSB+TRIG_WIDTH <= PROBE_WIDTH
OUT_WIDTH, 192, readback width; must be >= PROBE_WIDTH+8

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
probe_i  input  PROBE_WIDTH  sampled probe vector
cmd_i  input  32  software command register (level, held by software)
pretrig_i  input  LOG2_DEEP  pre-trigger sample count, sampled on ARM
trig_mask_i  input  TRIG_WIDTH  trigger compare mask (1 = compare bit)
trig_value_i  input  TRIG_WIDTH  trigger compare value
addr_i  input  32  logical readback address; low LOG2_DEEP bits used
data_o  output  OUT_WIDTH  {status[7:0], zero pad, sample[PROBE_WIDTH-1:0]}
state_o  output  3  current FSM state
done_o  output  1  capture complete
trig_addr_o  output  LOG2_DEEP  physical RAM address of trigger sample

Behaviour:
- Reset (async, rst_ni=0): state IDLE, wr_ptr=0, pre_cnt=0, post_cnt=0, trig_addr_o=0, done_o=0, data_o=0, RAM write enable 0. RAM contents undefined.
- Commands: CLEAR=32'hDEADDEAD, ARM=32'hDEADCAFE, FORCE=32'hDEADF00D; any other value = no-op. CLEAR wins over every state and event in the same cycle.
- Trigger hit: ((probe_i[TRIG_LSB+:TRIG_WIDTH] ^ trig_value_i) & trig_mask_i) == 0. Mask 0 means trigger on the first ARMED cycle.
- States: IDLE=0, FILL=1, ARMED=2, POST=3, DONE=4.
- IDLE: no writes. On ARM: latch pretrig_i into pre_len, set wr_ptr=0 and pre_cnt=0, then go to FILL (or straight to ARMED if pretrig_i==0).
- FILL: write probe_i at wr_ptr every cycle, wr_ptr++, pre_cnt++. When pre_cnt reaches pre_len-1 on a write, go to ARMED next cycle. Triggers and FORCE are ignored in FILL, which guarantees pre_len valid pre-samples.
- ARMED: write every cycle; wr_ptr wraps modulo DEPTH. On hit or FORCE: trig_addr_o=wr_ptr (this cycle's sample is the trigger sample), post_cnt=1, go to POST.
- POST: write every cycle, post_cnt++. The last write is the one at which post_cnt == DEPTH-pre_len. Then go to DONE with write enable low the next cycle. Total post-samples including the trigger sample = DEPTH-pre_len (>=1). If pre_len==DEPTH-1, POST exits after the trigger-cycle write only.
- DONE: done_o=1, no writes. ARM is ignored while in DONE because cmd_i is a held level; software must issue CLEAR, then ARM, to rearm.
- CLEAR mid-capture: go to IDLE next edge, write enable low the same cycle, done_o=0. RAM is not cleared.
- Readback: phys = (trig_addr_o - pre_len + addr_i[LOG2_DEEP-1:0]) mod DEPTH. The RAM read is registered (1 cycle) and data_o is registered (1 cycle), so data_o reflects addr_i from 2 cycles earlier. Readback is valid only in DONE; in other states the sample field is don't-care but status is still correct.
- Status byte data_o[OUT_WIDTH-1 -: 8] = {done_o, state_o[2:0], 4'b0}. Pad bits are always 0.
- Width arithmetic: pointers and pre_cnt are LOG2_DEEP bits, wrap naturally. post_cnt is LOG2_DEEP+1 bits so DEPTH is representable.
- A write and a readback to the same physical address in the same cycle return old data (read-first). This only matters outside DONE.

Decomposition:
- Package logic_thief_pkg:
  - command constants CMD_CLEAR, CMD_ARM, CMD_FORCE
  - state encoding (3-bit typedef, IDLE..DONE)
  - STATUS_WIDTH=8
- One sub-module: lt_capture_ram, a simple dual-port RAM (port A write-only, port B registered read-only, read-first), parametrised by width and log2 depth.

Test Plan:
- Reset then CLEAR; probe = cycle counter, pretrig_i=16, mask=8'hFF, value=8'h80, ARM; field hits 0x80 at the first ARMED cycle ≥ cycle 16 -> DONE after 256 total writes. addr_i=16 reads the trigger sample (field 0x80); addr_i=0 reads the trigger sample minus 16; addr_i=255 reads the trigger sample plus 239. Status byte is 0xC0.
- pretrig_i=0, mask=0 -> trigger on the first ARMED cycle; 256 post-samples; addr_i=0 returns the trigger sample; done_o after exactly 256 write cycles.
- pretrig_i=255, trigger value never occurs, FORCE after 1000 cycles -> wr_ptr has wrapped; addr_i=255 returns the forced sample; addr_i=0 returns the sample 255 cycles earlier; done_o the next cycle.
- Trigger pattern present during FILL (pretrig_i=32, hit at cycle 5) -> ignored; the first hit after cycle 32 is captured; trig_addr_o matches.
- CLEAR asserted mid-POST -> state_o=0 next edge, no further writes, done_o stays 0. ARM held through DONE does not restart the capture.
- rst_ni pulsed low asynchronously mid-ARMED -> all outputs are 0 immediately; after release, state stays IDLE until CLEAR then ARM.
